edf_irq_gateway: RTL
====================

Name: edf_irq_gateway

Overview:
Upstream stage of the EDF interrupt controller. It edge-detects the parallel interrupt lines and stamps each accepted request with an absolute deadline: a free-running timebase plus a per-line configured relative deadline. Pending requests are then serialised round-robin into the sequential priority queue over a valid/ready handshake. It owns the config-bus registers for interrupt enable and relative deadlines.

Parameters:
NrParIrqs, 2, number of parallel interrupt lines; must be at least 2.
TsWidth, 16, width of the timebase and deadlines, in bits.
IdWidth, $clog2(NrParIrqs), localparam; width of the interrupt ID.

Ports:
clk_i  in  1  clock; the only clock.
rst_i  in  1  reset; synchronous, active-high.
cfg_req_i  in  1  config write strobe; one write per cycle while high.
cfg_addr_i  in  32  config byte address.
cfg_wdata_i  in  32  config write data.
irq_i  in  NrParIrqs  interrupt lines; level inputs, rising edge = request.
pq_valid_o  out  1  stamped request available to the priority queue.
pq_ready_i  in  1  priority queue accepts the request.
pq_id_o  out  IdWidth  ID of the request.
pq_deadline_o  out  TsWidth  absolute deadline of the request.
time_o  out  TsWidth  current timebase, shared with the queue for deadline comparison.
drop_o  out  1  one-cycle pulse: a rising edge hit a line that was already pending.

Behaviour:
- Reset values: all outputs 0, all internal state 0 (timebase, enable mask, deadlines, pending bits, round-robin pointer, irq_i history). Reset asserted mid-transfer drops pq_valid_o on the next edge; the in-flight request is lost.
- Timebase: time_q increments by 1 every cycle and wraps modulo 2^TsWidth. time_o = time_q.
- Config, write-only. On a cycle with cfg_req_i=1:
  - addr 0x00: enable mask <= wdata[NrParIrqs-1:0].
  - addr 0x04+4*i (i < NrParIrqs): rel_dl[i] <= wdata[TsWidth-1:0].
  - Any other address is ignored; no error.
  - The written value is used from the next cycle.
- Edge detect: irq_q <= irq_i. A rising edge is irq_i & ~irq_q.
- Request acceptance, for line i with a rising edge in cycle t:
  - If en[i]=0: ignored.
  - If en[i]=1 and pending[i]=0: pending[i] <= 1 and abs_dl[i] <= time_q + rel_dl[i] (mod 2^TsWidth, carry discarded).
  - If en[i]=1 and pending[i]=1 and line i is not dispatched in cycle t: drop_o=1 in t+1; abs_dl[i] keeps its old value.
  - Edges on several lines in the same cycle are each accepted independently.
- Clearing the enable bit blocks only new edges; an existing pending request is still dispatched.
- Output register, loaded in any cycle where (!pq_valid_o || pq_ready_i):
  - Pick the first pending index at or after rr_ptr, searching cyclically.
  - If one is found: pq_valid_o <= 1, pq_id_o <= sel, pq_deadline_o <= abs_dl[sel], pending[sel] <= 0, rr_ptr <= (sel+1) mod NrParIrqs.
  - If none is found: pq_valid_o <= 0.
- Handshake: while pq_valid_o=1 and pq_ready_i=0, pq_valid_o, pq_id_o and pq_deadline_o hold stable. The transfer completes on a cycle with pq_valid_o && pq_ready_i.
- Simultaneous dispatch and new edge on the same line i in cycle t:
  - The dispatch carries the old abs_dl[i].
  - The set wins: pending[i]=1 with the new deadline; no drop.
- Latency: edge sampled in cycle t -> pending at t+1 -> pq_valid_o high at t+2 if the output register is free.
- Throughput: one request per cycle while pq_ready_i=1.

Test Plan:
- Reset: hold rst_i high for 3 cycles, then release. Required: all outputs 0; time_o counts 0,1,2,... after release.
- Single request: write en=0b01, rel_dl[0]=100; raise irq_i[0] at time_q=20 with pq_ready_i=1. Required: pq_valid_o high 2 cycles later with pq_id_o=0 and pq_deadline_o=120, high for exactly one cycle.
- Wrap-around: TsWidth=16, rel_dl[1]=0x0010, edge on line 1 at time_q=0xFFF8. Required: pq_deadline_o=0x0008.
- Backpressure and round-robin: enable both lines, pq_ready_i=0, edges on lines 0 and 1 in the same cycle. Required: pq_id_o=0 held stable for 5 cycles. Then set pq_ready_i=1. Required: IDs 0 then 1 on consecutive cycles, then pq_valid_o=0.
- Drop: line 0 pending and stalled with pq_ready_i=0; toggle irq_i[0] low then high. Required: one drop_o pulse; the deadline delivered later is the original one.
- Disabled line: en=0, edge on line 1. Required: no pq_valid_o and no drop_o. A write to address 0x40 leaves all observable state unchanged.

Source files
------------

// File: rtl/edf_irq_gateway.sv
// Upstream stage of the EDF interrupt controller: edge-detects interrupt lines,
// stamps each request with an absolute deadline and serialises them round-robin.
module edf_irq_gateway #(
    parameter int NrParIrqs = 2,
    parameter int TsWidth   = 16,
    localparam int IdWidth  = $clog2(NrParIrqs)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_req_i,
    input  logic [31:0]          cfg_addr_i,
    input  logic [31:0]          cfg_wdata_i,
    input  logic [NrParIrqs-1:0] irq_i,
    output logic                 pq_valid_o,
    input  logic                 pq_ready_i,
    output logic [IdWidth-1:0]   pq_id_o,
    output logic [TsWidth-1:0]   pq_deadline_o,
    output logic [TsWidth-1:0]   time_o,
    output logic                 drop_o
);

    logic [TsWidth-1:0]   time_q;
    logic [NrParIrqs-1:0] en_q;
    logic [NrParIrqs-1:0] irq_q;
    logic [NrParIrqs-1:0] pending_q;
    logic [TsWidth-1:0]   rel_dl_q [NrParIrqs];
    logic [TsWidth-1:0]   abs_dl_q [NrParIrqs];
    logic [IdWidth-1:0]   rr_ptr_q;
    logic                 valid_q;
    logic [IdWidth-1:0]   id_q;
    logic [TsWidth-1:0]   dl_q;
    logic                 drop_q;

    logic [NrParIrqs-1:0] rise;
    logic [NrParIrqs-1:0] accept;
    logic [NrParIrqs-1:0] dispatch;
    logic [NrParIrqs-1:0] pending_next;
    logic                 load;
    logic                 found;
    logic [IdWidth-1:0]   sel;
    logic                 drop_next;
    logic                 unused_wdata;

    // Only the low bits of the write data are meaningful for any register.
    assign unused_wdata = ^cfg_wdata_i;

    assign rise   = irq_i & ~irq_q;
    assign accept = rise & en_q;
    assign load   = !valid_q || pq_ready_i;

    // Cyclic search from rr_ptr: first pass covers indices at/after the pointer,
    // second pass wraps around to the lower indices.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NrParIrqs; i++) begin
            if (!found && pending_q[i] && (i >= int'(rr_ptr_q))) begin
                found = 1'b1;
                sel   = IdWidth'(i);
            end
        end
        for (int i = 0; i < NrParIrqs; i++) begin
            if (!found && pending_q[i]) begin
                found = 1'b1;
                sel   = IdWidth'(i);
            end
        end
    end

    always_comb begin
        dispatch = '0;
        if (load && found) begin
            dispatch[sel] = 1'b1;
        end
    end

    // A new edge on a line being dispatched this cycle re-arms it instead of dropping.
    assign pending_next = (pending_q & ~dispatch) | accept;
    assign drop_next    = |(accept & pending_q & ~dispatch);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            time_q <= '0;
            irq_q  <= '0;
            en_q   <= '0;
            for (int i = 0; i < NrParIrqs; i++) begin
                rel_dl_q[i] <= '0;
            end
        end else begin
            time_q <= time_q + 1'b1;
            irq_q  <= irq_i;
            if (cfg_req_i) begin
                if (cfg_addr_i == 32'h0) begin
                    en_q <= cfg_wdata_i[NrParIrqs-1:0];
                end
                for (int i = 0; i < NrParIrqs; i++) begin
                    if (cfg_addr_i == 32'(4 + 4 * i)) begin
                        rel_dl_q[i] <= cfg_wdata_i[TsWidth-1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
            drop_q    <= 1'b0;
            for (int i = 0; i < NrParIrqs; i++) begin
                abs_dl_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_next;
            drop_q    <= drop_next;
            for (int i = 0; i < NrParIrqs; i++) begin
                if (accept[i] && (!pending_q[i] || dispatch[i])) begin
                    abs_dl_q[i] <= time_q + rel_dl_q[i];
                end
            end
        end
    end

    // Output register toward the priority queue; holds while stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            id_q     <= '0;
            dl_q     <= '0;
            rr_ptr_q <= '0;
        end else if (load) begin
            valid_q <= found;
            if (found) begin
                id_q <= sel;
                dl_q <= abs_dl_q[sel];
                if (int'(sel) == NrParIrqs - 1) begin
                    rr_ptr_q <= '0;
                end else begin
                    rr_ptr_q <= sel + 1'b1;
                end
            end
        end
    end

    assign pq_valid_o    = valid_q;
    assign pq_id_o       = id_q;
    assign pq_deadline_o = dl_q;
    assign time_o        = time_q;
    assign drop_o        = drop_q;

endmodule
